// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: multiply/divide unit state and timing.
package mips_pkg;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    // Operand width of the multiply/divide unit.
    localparam int unsigned MD_WIDTH = 32;

    // Cycles from issue edge to HI/LO update; hazard logic stalls for this long.
    localparam int unsigned MD_LATENCY = MD_WIDTH + 1;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit owning the HI/LO registers.
// Works on operand magnitudes (shift-add multiply, restoring divide, one bit per
// cycle) and applies result signs in a single FIX cycle before writing HI/LO.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic             multE,
    input  logic             divE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Two's-complement magnitude; the most negative value maps to itself, which is
    // exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    md_state_t          state_q;
    logic [CNTW-1:0]    cnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    // MUL: running product. DIV: unused.
    logic [2*WIDTH-1:0] acc_q;
    // MUL: multiplicand magnitude, shifted left each step. DIV: divisor magnitude in low half.
    logic [2*WIDTH-1:0] mcand_q;
    // MUL: multiplier bits, consumed from bit 0. DIV: dividend bits out, quotient bits in.
    logic [WIDTH-1:0]   shift_q;
    // DIV: partial remainder.
    logic [WIDTH:0]     rem_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               is_div_q;

    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_dvsr;
    logic               div_ok;
    logic [WIDTH:0]     rem_d;
    logic               issue;
    logic               last_iter;

    // Per-iteration datapath for both algorithms.
    always_comb begin
        mul_acc_d = shift_q[0] ? (acc_q + mcand_q) : acc_q;
        div_shift = {rem_q, shift_q[WIDTH-1]};
        div_dvsr  = {2'b00, mcand_q[WIDTH-1:0]};
        div_ok    = (div_shift >= div_dvsr);
        rem_d     = div_ok ? (WIDTH+1)'(div_shift - div_dvsr) : (WIDTH+1)'(div_shift);
        issue     = startE & (multE | divE);
        last_iter = (cnt_q == CNTW'(WIDTH - 1));
    end

    // Sequencer: issue, WIDTH iterations, sign fix-up and HI/LO writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            shift_q   <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        acc_q     <= '0;
                        rem_q     <= '0;
                        neg_rem_q <= srcaE[WIDTH-1];
                        if (multE) begin
                            // mult wins when both opcodes are asserted
                            state_q   <= MUL;
                            is_div_q  <= 1'b0;
                            mcand_q   <= {{WIDTH{1'b0}}, mag(srcaE)};
                            shift_q   <= mag(srcbE);
                            neg_res_q <= srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
                        end else begin
                            state_q   <= DIV;
                            is_div_q  <= 1'b1;
                            mcand_q   <= {{WIDTH{1'b0}}, mag(srcbE)};
                            shift_q   <= mag(srcaE);
                            // divide by zero keeps the all-ones quotient unsigned
                            neg_res_q <= (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]) & (|srcbE);
                        end
                    end
                end
                MUL: begin
                    acc_q   <= mul_acc_d;
                    mcand_q <= mcand_q << 1;
                    shift_q <= shift_q >> 1;
                    cnt_q   <= cnt_q + CNTW'(1);
                    if (last_iter) begin
                        state_q <= FIX;
                    end
                end
                DIV: begin
                    rem_q   <= rem_d;
                    shift_q <= {shift_q[WIDTH-2:0], div_ok};
                    cnt_q   <= cnt_q + CNTW'(1);
                    if (last_iter) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        lo_q <= neg_if(neg_res_q, shift_q);
                        hi_q <= neg_if(neg_rem_q, rem_q[WIDTH-1:0]);
                    end else begin
                        {hi_q, lo_q} <= neg2_if(neg_res_q, acc_q);
                    end
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// mult/div traffic compared against plain signed 64-bit arithmetic.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        startE;
    logic        multE;
    logic        divE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural HI/LO as the reference model sees them.
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    muldiv_unit #(
        .WIDTH (32),
        .CNTW  (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .multE  (multE),
        .divE   (divE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result from the architectural definition of mult/div.
    task automatic ref_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            p   = sa * sb;
            rhi = p[63:32];
            rlo = p[31:0];
        end else if (b == 32'd0) begin
            rhi = a;
            rlo = 32'hFFFF_FFFF;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            rhi = r[31:0];
            rlo = q[31:0];
        end
    endtask

    // Issue one op, optionally pulse a stray div 9/3 at busy cycle inject_at, and
    // check latency, HI/LO hold while busy, and the final result.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int inject_at);
        logic [31:0] ehi;
        logic [31:0] elo;
        int          cycles;
        logic        hold_ok;
        ref_op(m, a, b, ehi, elo);
        @(negedge clk);
        startE = 1'b1;
        multE  = m;
        divE   = d;
        srcaE  = a;
        srcbE  = b;
        @(negedge clk);
        startE  = 1'b0;
        multE   = 1'b0;
        divE    = 1'b0;
        cycles  = 0;
        hold_ok = 1'b1;
        while (busy && cycles < 100) begin
            cycles++;
            if (hi !== mdl_hi || lo !== mdl_lo) hold_ok = 1'b0;
            if (cycles == inject_at) begin
                startE = 1'b1;
                divE   = 1'b1;
                srcaE  = 32'd9;
                srcbE  = 32'd3;
            end else begin
                startE = 1'b0;
                divE   = 1'b0;
            end
            @(negedge clk);
        end
        startE = 1'b0;
        divE   = 1'b0;
        check_eq({tag, " latency"}, 64'(cycles), 64'(MD_LATENCY));
        check_eq({tag, " hold"}, 64'(hold_ok), 64'd1);
        check_eq({tag, " hi"}, 64'(hi), 64'(ehi));
        check_eq({tag, " lo"}, 64'(lo), 64'(elo));
        mdl_hi = ehi;
        mdl_lo = elo;
    endtask

    initial begin
        reset  = 1'b0;
        startE = 1'b0;
        multE  = 1'b0;
        divE   = 1'b0;
        srcaE  = '0;
        srcbE  = '0;
        #12;
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset hi", 64'(hi), 64'd0);
        check_eq("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed corner cases.
        run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        check_eq("mul 7*-3 hi const", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mul 7*-3 lo const", 64'(lo), 64'hFFFF_FFEB);
        run_op("mul -1*-1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul max*2", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 0);
        run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("div -7/2 lo const", 64'(lo), 64'hFFFF_FFFD);
        run_op("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 0);
        check_eq("div 100/7 lo const", 64'(lo), 64'd14);
        run_op("div by 0", 1'b0, 1'b1, 32'h1234_5678, 32'd0, 0);
        run_op("div ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("div ovf lo const", 64'(lo), 64'h8000_0000);
        run_op("mul+div both", 1'b1, 1'b1, 32'd6, 32'hFFFF_FFF9, 0);
        run_op("mul ignore div", 1'b1, 1'b0, 32'h0001_2345, 32'h0000_0100, 10);

        // startE with no opcode does nothing.
        @(negedge clk);
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        check_eq("noop busy", 64'(busy), 64'd0);
        check_eq("noop hi", 64'(hi), 64'(mdl_hi));

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        startE = 1'b1;
        divE   = 1'b1;
        srcaE  = 32'd100;
        srcbE  = 32'd7;
        @(negedge clk);
        startE = 1'b0;
        divE   = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("abort busy", 64'(busy), 64'd0);
        check_eq("abort hi", 64'(hi), 64'd0);
        check_eq("abort lo", 64'(lo), 64'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op("mul 3*4", 1'b1, 1'b0, 32'd3, 32'd4, 0);

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            int unsigned sel;
            logic [31:0] a;
            logic [31:0] b;
            sel = $urandom_range(0, 3);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 31);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
            if (sel == 2 && $urandom_range(0, 7) == 0) b = '0;
            run_op("rand", (sel != 2), (sel >= 2), a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative signed multiply/divide unit attached to the execute stage of the pipelined MIPS datapath. It consumes multE/divE and the forwarded operands, and owns the HI/LO architectural registers. Writeback reads HI/LO through movhiW/movloW. It raises busy so hazard logic can stall the pipeline while an operation runs.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each, product is 2*WIDTH.
CNTW, 6, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
startE  input  1  issue qualifier: E-stage instruction is valid and not stalled/flushed.
multE  input  1  mult opcode in E (signed).
divE  input  1  div opcode in E (signed).
srcaE  input  WIDTH  forwarded rs operand (multiplicand / dividend).
srcbE  input  WIDTH  forwarded rt operand (multiplier / divisor).
busy  output  1  operation in flight; HI/LO not yet valid.
hi  output  WIDTH  HI register (product high half / remainder).
lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, hi=0, lo=0, counter=0, internal accumulators=0.
- Issue: in IDLE, startE & (multE|divE) on a rising edge latches |srcaE|, |srcbE| (unsigned magnitudes), result sign flags, and the opcode; goes to MUL or DIV; busy=1 from that edge.
- multE & divE both high: treat as mult.
- startE with neither op: no effect. startE while busy: ignored, no state change; hazard logic must stall instead.
- FSM: IDLE -> MUL|DIV -> (WIDTH iterations, counter 0..WIDTH-1) -> FIX -> IDLE.
- MUL: radix-2 shift-add on the 2*WIDTH unsigned product, one multiplier bit per cycle.
- DIV: radix-2 restoring division, one quotient bit per cycle; remainder is WIDTH+1 bits internally.
- FIX (1 cycle): applies signs and writes hi/lo.
  - mult: negate the 64-bit product if sign(a) xor sign(b).
  - div: negate quotient if sign(a) xor sign(b); negate remainder if sign(a).
- Latency: the issue edge is edge 0; hi/lo update at edge WIDTH+1 (33); busy falls at the same edge. busy is high for exactly WIDTH+1 cycles.
- hi/lo are stable at all other times; the previous values stay visible while busy.
- Divide by zero: completes with normal latency; lo=all ones, hi=srcaE (original signed dividend).
- Overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm; no special case.
- Reset mid-operation: aborts immediately, hi=lo=0, IDLE; no partial result is written.
- No cancel input: a mult/div that has issued always completes. Upstream asserts startE only for non-flushed instructions.

Decomposition:
- Shared package mips_pkg:
  - md_state_t enum {IDLE, MUL, DIV, FIX}.
  - MD_WIDTH=32.
  - MD_LATENCY=MD_WIDTH+1, for hazard-unit and bench use.
- Single module. Sign/magnitude helpers are local functions. A sub-module is not warranted.

Test Plan:
- mult 7 × 0xFFFFFFFD (-3): busy high 33 cycles -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=0 on the same edge hi/lo update.
- mult 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1. mult 0x7FFFFFFF × 2 -> hi=0, lo=0xFFFFFFFE.
- div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 100/7 -> lo=14, hi=2.
- div 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678 after 33 cycles. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue a mult, then at cycle 10 pulse startE with div 9/3 -> ignored; the first mult's result appears at cycle 33; hi/lo hold old values throughout.
- Issue a div, drop reset to 0 at cycle 15 asynchronously (mid-cycle) -> busy=0, hi=lo=0 immediately. Release reset, issue mult 3×4 -> lo=12, hi=0 after 33 cycles.
